// File: rtl/bshift_pkg.sv
// Shared op encodings and per-stage shift helpers for the pipelined barrel shifter.
// Helpers work on a 64-bit container; callers pass their real width in w.
package bshift_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam int MAX_W = 64;

  // Word after a fixed shift of 2^k; bits at and above w are returned as zero.
  function automatic logic [MAX_W-1:0] stage_shift(input logic [MAX_W-1:0] d,
                                                   input logic [1:0] op,
                                                   input logic fill,
                                                   input int k,
                                                   input int w);
    int s;
    s = 1 << k;
    stage_shift = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        case (op)
          OP_ROL:  stage_shift[6'(i)] = d[6'((i - s + w) % w)];
          OP_ROR:  stage_shift[6'(i)] = d[6'((i + s) % w)];
          OP_SLL:  stage_shift[6'(i)] = (i >= s) ? d[6'(i - s)] : 1'b0;
          default: stage_shift[6'(i)] = (i + s < w) ? d[6'(i + s)] : fill;
        endcase
      end
    end
  endfunction

  // Last bit moved out by a 2^k shift of d (q is the shifted word).
  function automatic logic stage_carry(input logic [MAX_W-1:0] d,
                                       input logic [MAX_W-1:0] q,
                                       input logic [1:0] op,
                                       input int k,
                                       input int w);
    int s;
    s = 1 << k;
    case (op)
      OP_ROL:  stage_carry = q[0];
      OP_ROR:  stage_carry = q[6'(w - 1)];
      OP_SLL:  stage_carry = d[6'(w - s)];
      default: stage_carry = d[6'(s - 1)];
    endcase
  endfunction

endpackage

// File: rtl/bshift_stage.sv
// One pipeline stage: conditional 2^STAGE shift, registered with a global hold enable.
// Optional carry register under BSHIFT_CARRY_OUT_EN.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STAGE = 0,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic [AW-1:0]    src_amt,
  input  logic [1:0]       src_op,
  input  logic             src_fill,
`ifdef BSHIFT_CARRY_OUT_EN
  input  logic             src_carry,
  output logic             carry,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    amt,
  output logic [1:0]       op,
  output logic             fill
);

  logic             take;
  logic [WIDTH-1:0] shifted;

  assign take    = src_amt[STAGE];
  assign shifted = WIDTH'(stage_shift(64'(src_data), src_op, src_fill, STAGE, WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= '0;
      fill  <= 1'b0;
    end else if (en) begin
      valid <= src_valid;
      data  <= take ? shifted : src_data;
      amt   <= src_amt;
      op    <= src_op;
      fill  <= src_fill;
    end
  end

`ifdef BSHIFT_CARRY_OUT_EN
  logic shift_carry;
  assign shift_carry = stage_carry(64'(src_data), 64'(shifted), src_op, STAGE, WIDTH);

  always_ff @(posedge clk) begin
    if (rst)     carry <= 1'b0;
    else if (en) carry <= take ? shift_carry : src_carry;
  end
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit: input register plus one stage per amount bit, global stall.
// Define BSHIFT_CARRY_OUT_EN to add the out_carry port.
module pipelined_barrel_shifter
  import bshift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BSHIFT_CARRY_OUT_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 2 || WIDTH > MAX_W || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two in 2..64");
  end

  logic en;
  logic head_valid, head_fill;
  logic [WIDTH-1:0] head_data;
  logic [SW-1:0] head_amt;
  logic [1:0] head_op;

  logic [SW:0]            vld_pipe;
  logic [SW:0][WIDTH-1:0] data_pipe;
  logic [SW:0][SW-1:0]    amt_pipe;
  logic [SW:0][1:0]       op_pipe;
  logic [SW:0]            fill_pipe;

  // A stalled output freezes every stage, so nothing upstream may move either.
  assign en        = ~(vld_pipe[SW] & ~out_ready);
  assign in_ready  = en;
  assign out_valid = vld_pipe[SW];
  assign out_data  = data_pipe[SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_amt   <= '0;
      head_op    <= '0;
      head_fill  <= 1'b0;
    end else if (en) begin
      head_valid <= in_valid;
      head_data  <= in_data;
      head_amt   <= in_amt;
      head_op    <= in_op;
      head_fill  <= in_data[WIDTH-1];
    end
  end

  assign vld_pipe[0]  = head_valid;
  assign data_pipe[0] = head_data;
  assign amt_pipe[0]  = head_amt;
  assign op_pipe[0]   = head_op;
  assign fill_pipe[0] = head_fill;

`ifdef BSHIFT_CARRY_OUT_EN
  logic [SW:0] carry_pipe;
  assign carry_pipe[0] = 1'b0;
  assign out_carry     = carry_pipe[SW];
`endif

  for (genvar k = 0; k < SW; k++) begin : g_stage
    bshift_stage #(.WIDTH(WIDTH), .STAGE(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .src_valid (vld_pipe[k]),
      .src_data  (data_pipe[k]),
      .src_amt   (amt_pipe[k]),
      .src_op    (op_pipe[k]),
      .src_fill  (fill_pipe[k]),
`ifdef BSHIFT_CARRY_OUT_EN
      .src_carry (carry_pipe[k]),
      .carry     (carry_pipe[k+1]),
`endif
      .valid     (vld_pipe[k+1]),
      .data      (data_pipe[k+1]),
      .amt       (amt_pipe[k+1]),
      .op        (op_pipe[k+1]),
      .fill      (fill_pipe[k+1])
    );
  end

  logic unused;
  assign unused = ^{amt_pipe[SW], op_pipe[SW], fill_pipe[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=16): queue model with per-item age in enabled edges.
// Build with BSHIFT_CARRY_OUT_EN to also check out_carry.
module tb_pipelined_barrel_shifter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0] in_op = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_data;
`ifdef BSHIFT_CARRY_OUT_EN
  logic out_carry;
`endif

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BSHIFT_CARRY_OUT_EN
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_in = 0;
  int dut_out = 0;
  bit started = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int           age;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_res(input logic [W-1:0] d, input int a, input logic [1:0] op);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   m_res = W'((dd << a) >> W);
      2'b01:   m_res = W'(dd >> a);
      2'b10:   m_res = W'(d << a);
      default: m_res = W'($signed(d) >>> a);
    endcase
  endfunction

  function automatic logic m_car(input logic [W-1:0] d, input int a, input logic [1:0] op);
    logic [W-1:0] r;
    r = m_res(d, a, op);
    if (a == 0) m_car = 1'b0;
    else case (op)
      2'b00:   m_car = r[0];
      2'b01:   m_car = r[W-1];
      2'b10:   m_car = d[W-a];
      default: m_car = d[a-1];
    endcase
  endfunction

  // Check against the model, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    bit eov;
    eov = (q.size() > 0) && (q[0].age == SW + 1);
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(!(eov && !out_ready)));
      chk("out_valid", 32'(out_valid), 32'(eov));
      if (eov && out_valid) begin
        chk("out_data", 32'(out_data), 32'(q[0].d));
`ifdef BSHIFT_CARRY_OUT_EN
        chk("out_carry", 32'(out_carry), 32'(q[0].c));
`endif
      end
    end
    if (out_valid === 1'b1 && out_ready && !rst) dut_out++;
    if (rst) q.delete();
    else if (!(eov && !out_ready)) begin
      if (eov) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (in_valid) begin
        ent_t e;
        e.d = m_res(in_data, int'(in_amt), in_op);
        e.c = m_car(in_data, int'(in_amt), in_op);
        e.age = 1;
        q.push_back(e);
        n_in++;
      end
    end
    if (rst) started = 1;
  end

  task automatic send_and_expect(input logic [W-1:0] d, input int a, input logic [1:0] op,
                                 input logic [W-1:0] exp, input logic expc, input string name);
    int cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_amt = SW'(a); in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({name, "_latency"}, 32'(cnt), 32'(SW));
    chk({name, "_data"}, 32'(out_data), 32'(exp));
`ifdef BSHIFT_CARRY_OUT_EN
    chk({name, "_carry"}, 32'(out_carry), 32'(expc));
`else
    if (expc === 1'bx) $display("carry expectation unknown for %s", name);
`endif
  endtask

  task automatic drive_rand(input bit v);
    in_valid = v;
    in_data  = W'($urandom);
    in_amt   = SW'($urandom);
    in_op    = 2'($urandom);
  endtask

  initial begin
    int base_in, base_out;
    logic [W-1:0] held;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    chk("model_rol", 32'(m_res(16'h8001, 1, 2'b00)), 32'h0003);
    chk("model_ror", 32'(m_res(16'h0001, 4, 2'b01)), 32'h1000);
    chk("model_sll", 32'(m_res(16'hFFFF, 8, 2'b10)), 32'hFF00);
    chk("model_sra", 32'(m_res(16'h8000, 15, 2'b11)), 32'hFFFF);
    chk("model_sll_carry", 32'(m_car(16'hFFFF, 8, 2'b10)), 32'd1);
    chk("model_sra_carry", 32'(m_car(16'h8000, 15, 2'b11)), 32'd0);

    send_and_expect(16'h8001, 1, 2'b00, 16'h0003, 1'b1, "rol");
    send_and_expect(16'h0001, 4, 2'b01, 16'h1000, 1'b0, "ror");
    send_and_expect(16'hFFFF, 8, 2'b10, 16'hFF00, 1'b1, "sll");
    send_and_expect(16'h8000, 15, 2'b11, 16'hFFFF, 1'b0, "sra");
    for (int op = 0; op < 4; op++)
      send_and_expect(16'hA5C3, 0, 2'(op), 16'hA5C3, 1'b0, "amt0");

    // Back-to-back stream
    @(posedge clk); #1;
    base_out = dut_out;
    for (int i = 0; i < 20; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (SW + 3) @(posedge clk);
    #1;
    chk("stream_count", 32'(dut_out - base_out), 32'd20);

    // Backpressure with the pipe full
    base_in = n_in; base_out = dut_out;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    held = out_data;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
    chk("stall_data_hold", 32'(out_data), 32'(held));
    chk("stall_accepted", 32'(n_in - base_in), 32'(SW + 1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (SW + 4) @(posedge clk);
    #1;
    chk("stall_no_loss", 32'(dut_out - base_out), 32'(n_in - base_in));

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    base_out = dut_out;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (SW + 3) @(posedge clk);
    #1;
    chk("reset_discard", 32'(dut_out - base_out), 32'd0);
    send_and_expect(16'h1234, 4, 2'b00, 16'h2341, 1'b1, "post_reset");

    // Random valid/ready mix
    @(posedge clk); #1;
    base_in = n_in; base_out = dut_out;
    for (int i = 0; i < 300; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (SW + 4) @(posedge clk);
    #1;
    chk("random_no_loss", 32'(dut_out - base_out), 32'(n_in - base_in));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
